// File: rtl/action_ram_arbiter.sv
// action_ram_arbiter: shares the single-port action RAM between readers A/B and one writer; ACTION_ARB_STATS_EN adds grant counters
module action_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rd_req_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic              rd_ack_a,
    output logic              rd_valid_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic              rd_req_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic              rd_ack_b,
    output logic              rd_valid_b,
    output logic [DATA_W-1:0] rd_data_b,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic [DATA_W-1:0] ram_d_in,
    output logic              ram_write_enable,
    input  logic [DATA_W-1:0] ram_d_out
`ifdef ACTION_ARB_STATS_EN
    ,
    output logic [15:0]       stat_rd_a,
    output logic [15:0]       stat_rd_b,
    output logic [15:0]       stat_wr
`endif
);
    typedef enum logic [1:0] {IDLE, RD_ADDR, RD_CAP, WR} state_t;
    state_t state;
    logic   rr_b;
    logic   owner_b;
    logic   pick_a;
    logic   pick_b;
    // rr_b set means B wins a tie; a lone reader is granted regardless
    always_comb begin
        pick_a = rd_req_a && (!rd_req_b || !rr_b);
        pick_b = rd_req_b && !pick_a;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            rr_b              <= 1'b0;
            owner_b           <= 1'b0;
            rd_ack_a          <= 1'b0;
            rd_ack_b          <= 1'b0;
            rd_valid_a        <= 1'b0;
            rd_valid_b        <= 1'b0;
            rd_data_a         <= '0;
            rd_data_b         <= '0;
            wr_ack            <= 1'b0;
            ram_read_address  <= '0;
            ram_write_address <= '0;
            ram_d_in          <= '0;
            ram_write_enable  <= 1'b0;
        end else begin
            rd_ack_a   <= 1'b0;
            rd_ack_b   <= 1'b0;
            rd_valid_a <= 1'b0;
            rd_valid_b <= 1'b0;
            wr_ack     <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        state             <= WR;
                        wr_ack            <= 1'b1;
                        ram_write_enable  <= 1'b1;
                        ram_write_address <= wr_addr;
                        ram_d_in          <= wr_data;
                    end else if (pick_a || pick_b) begin
                        state            <= RD_ADDR;
                        rd_ack_a         <= pick_a;
                        rd_ack_b         <= pick_b;
                        owner_b          <= pick_b;
                        rr_b             <= pick_a;
                        ram_read_address <= pick_b ? rd_addr_b : rd_addr_a;
                    end
                end
                RD_ADDR: state <= RD_CAP;
                RD_CAP: begin
                    state <= IDLE;
                    if (owner_b) begin
                        rd_data_b  <= ram_d_out;
                        rd_valid_b <= 1'b1;
                    end else begin
                        rd_data_a  <= ram_d_out;
                        rd_valid_a <= 1'b1;
                    end
                end
                WR: begin
                    state            <= IDLE;
                    ram_write_enable <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
`ifdef ACTION_ARB_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stat_rd_a <= '0;
            stat_rd_b <= '0;
            stat_wr   <= '0;
        end else if (state == IDLE) begin
            if (wr_req && stat_wr != 16'hFFFF) stat_wr <= stat_wr + 16'd1;
            if (!wr_req && pick_a && stat_rd_a != 16'hFFFF) stat_rd_a <= stat_rd_a + 16'd1;
            if (!wr_req && pick_b && stat_rd_b != 16'hFFFF) stat_rd_b <= stat_rd_b + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_action_ram_arbiter.sv
// tb_action_ram_arbiter: directed and randomized checks of action_ram_arbiter against a transaction-level model
module tb_action_ram_arbiter;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rd_req_a = 1'b0, rd_req_b = 1'b0, wr_req = 1'b0;
    logic [7:0]  rd_addr_a = '0, rd_addr_b = '0, wr_addr = '0;
    logic [15:0] wr_data = '0;
    logic        rd_ack_a, rd_valid_a, rd_ack_b, rd_valid_b, wr_ack, ram_write_enable;
    logic [15:0] rd_data_a, rd_data_b, ram_d_in;
    logic [15:0] ram_d_out = '0;
    logic [7:0]  ram_read_address, ram_write_address;
`ifdef ACTION_ARB_STATS_EN
    logic [15:0] stat_rd_a, stat_rd_b, stat_wr;
`endif
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    logic        rr_b = 1'b0;
    int          cnt_a = 0, cnt_b = 0, cnt_wr = 0;
    int          n_chk = 0, n_fail = 0;

    always #5 clock = ~clock;

    // behavioural single-port RAM: d_out refreshes only on non-write cycles
    always @(posedge clock) begin
        if (ram_write_enable) mem[ram_write_address] <= ram_d_in;
        else ram_d_out <= mem[ram_read_address];
    end

    action_ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (
        .clock(clock), .reset(reset),
        .rd_req_a(rd_req_a), .rd_addr_a(rd_addr_a), .rd_ack_a(rd_ack_a),
        .rd_valid_a(rd_valid_a), .rd_data_a(rd_data_a),
        .rd_req_b(rd_req_b), .rd_addr_b(rd_addr_b), .rd_ack_b(rd_ack_b),
        .rd_valid_b(rd_valid_b), .rd_data_b(rd_data_b),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_read_address(ram_read_address), .ram_write_address(ram_write_address),
        .ram_d_in(ram_d_in), .ram_write_enable(ram_write_enable), .ram_d_out(ram_d_out)
`ifdef ACTION_ARB_STATS_EN
        , .stat_rd_a(stat_rd_a), .stat_rd_b(stat_rd_b), .stat_wr(stat_wr)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_reset_values();
        chk("rst_ack_a", rd_ack_a, 0);
        chk("rst_ack_b", rd_ack_b, 0);
        chk("rst_wr_ack", wr_ack, 0);
        chk("rst_valid_a", rd_valid_a, 0);
        chk("rst_valid_b", rd_valid_b, 0);
        chk("rst_data_a", rd_data_a, 0);
        chk("rst_data_b", rd_data_b, 0);
        chk("rst_raddr", ram_read_address, 0);
        chk("rst_waddr", ram_write_address, 0);
        chk("rst_din", ram_d_in, 0);
        chk("rst_we", ram_write_enable, 0);
    endtask

    // Model: write goes first (ack at +1, idle again at +2); each read acks at t+1,
    // delivers at t+3 and frees the arbiter at t+3; readers ordered by the rr pointer.
    task automatic run_ops(input logic ra, input logic [7:0] aa, input logic rb, input logic [7:0] ab,
                           input logic w, input logic [7:0] aw, input logic [15:0] dw);
        int ea_ack = 0, ea_val = 0, eb_ack = 0, eb_val = 0, ew_ack = 0, t = 0;
        int ga_ack = 0, ga_val = 0, gb_ack = 0, gb_val = 0, gw_ack = 0;
        int na = 0, nb = 0, nw = 0, nva = 0, nvb = 0;
        logic [15:0] da = '0, db = '0, xa, xb;
        logic first_b;
        if (w) begin ew_ack = 1; t = 2; ref_mem[aw] = dw; cnt_wr++; end
        first_b = rb && (!ra || rr_b);
        xa = ref_mem[aa];
        xb = ref_mem[ab];
        if (first_b) begin eb_ack = t + 1; eb_val = t + 3; t += 3; rr_b = 1'b0; cnt_b++; end
        if (ra) begin ea_ack = t + 1; ea_val = t + 3; t += 3; rr_b = 1'b1; cnt_a++; end
        if (rb && !first_b) begin eb_ack = t + 1; eb_val = t + 3; t += 3; rr_b = 1'b0; cnt_b++; end
        rd_req_a = ra; rd_addr_a = aa;
        rd_req_b = rb; rd_addr_b = ab;
        wr_req = w; wr_addr = aw; wr_data = dw;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (rd_ack_a) begin na++; ga_ack = c; rd_req_a = 1'b0; chk("raddr_a", ram_read_address, aa); end
            if (rd_ack_b) begin nb++; gb_ack = c; rd_req_b = 1'b0; chk("raddr_b", ram_read_address, ab); end
            if (wr_ack) begin
                nw++; gw_ack = c; wr_req = 1'b0;
                chk("waddr", ram_write_address, aw);
                chk("wdata", ram_d_in, dw);
            end
            if (rd_valid_a) begin nva++; ga_val = c; da = rd_data_a; end
            if (rd_valid_b) begin nvb++; gb_val = c; db = rd_data_b; end
            chk("we_window", ram_write_enable, (w && c == 1) ? 1 : 0);
        end
        rd_req_a = 1'b0; rd_req_b = 1'b0; wr_req = 1'b0;
        chk("n_ack_a", na, ra ? 1 : 0);
        chk("n_ack_b", nb, rb ? 1 : 0);
        chk("n_wr_ack", nw, w ? 1 : 0);
        chk("n_valid_a", nva, ra ? 1 : 0);
        chk("n_valid_b", nvb, rb ? 1 : 0);
        chk("cyc_ack_a", ga_ack, ea_ack);
        chk("cyc_ack_b", gb_ack, eb_ack);
        chk("cyc_wr_ack", gw_ack, ew_ack);
        chk("cyc_valid_a", ga_val, ea_val);
        chk("cyc_valid_b", gb_val, eb_val);
        if (ra) chk("data_a", da, xa);
        if (rb) chk("data_b", db, xb);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        tick();
        tick();
        chk_reset_values();
        reset = 1'b0;
        // preload every address the reads below may touch
        for (int i = 0; i < 16; i++) run_ops(0, 0, 0, 0, 1, 8'(i), 16'($urandom));
        run_ops(0, 0, 0, 0, 1, 8'h05, 16'h1234);
        run_ops(1, 8'h05, 0, 0, 0, 0, 0);
        // reset in the cycle after rd_ack_b drops the read
        rd_req_b = 1'b1; rd_addr_b = 8'h03;
        tick();
        chk("rst_seq_ack_b", rd_ack_b, 1);
        rd_req_b = 1'b0;
        reset = 1'b1;
        tick();
        chk_reset_values();
        reset = 1'b0;
        rr_b = 1'b0; cnt_a = 0; cnt_b = 0; cnt_wr = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_no_valid_b", rd_valid_b, 0);
            chk("rst_no_we", ram_write_enable, 0);
        end
        run_ops(1, 8'h01, 1, 8'h02, 0, 0, 0);
        run_ops(1, 8'h01, 1, 8'h02, 0, 0, 0);
        run_ops(1, 8'h05, 0, 0, 1, 8'h05, 16'hBEEF);
        for (int i = 0; i < 4; i++) run_ops(0, 0, 0, 0, 1, 8'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 4; i++) run_ops(1, 8'(i), 0, 0, 0, 0, 0);
        for (int i = 0; i < 30; i++) begin
            logic ra, rb, w;
            ra = 1'($urandom_range(0, 1));
            rb = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            if (!ra && !rb && !w) ra = 1'b1;
            run_ops(ra, 8'($urandom_range(0, 15)), rb, 8'($urandom_range(0, 15)),
                    w, 8'($urandom_range(0, 15)), 16'($urandom));
        end
`ifdef ACTION_ARB_STATS_EN
        chk("stat_rd_a", stat_rd_a, cnt_a);
        chk("stat_rd_b", stat_rd_b, cnt_b);
        chk("stat_wr", stat_wr, cnt_wr);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
